// File: rtl/spy_readout_arbiter.sv
// Spy/readout arbiter: per-source FIFOs drained round-robin onto one registered
// output stream, with an orbit marker word inserted after every BC0.
//
// state  | meaning
// S_RUN  | grant data words round-robin; divert to S_MARK when a marker is pending
// S_MARK | load the orbit marker word, clear the pending flag, bump the orbit count
module spy_readout_arbiter #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_W     = 36,
    parameter int BX_W       = 3,
    parameter int FIFO_DEPTH = 8,
    parameter int SRC_W      = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       BC0,
    input  logic [NUM_SRC-1:0]         src_wr_en,
    input  logic [NUM_SRC*BX_W-1:0]    src_bx,
    input  logic [NUM_SRC*DATA_W-1:0]  src_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_marker,
    output logic [SRC_W-1:0]           out_src,
    output logic [BX_W-1:0]            out_bx,
    output logic [DATA_W-1:0]          out_data,
    output logic [NUM_SRC-1:0]         ovf,
    output logic [15:0]                drop_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int ENT_W = BX_W + DATA_W;
    localparam int CNT_W = $clog2(NUM_SRC + 1);
    localparam logic [PTR_W:0] PTR_ONE = 1;

    typedef enum logic [0:0] {
        S_RUN  = 1'b0,
        S_MARK = 1'b1
    } state_t;

    state_t state;

    logic [ENT_W-1:0] mem    [NUM_SRC][FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr [NUM_SRC];
    logic [PTR_W:0]   rd_ptr [NUM_SRC];
    logic [PTR_W:0]   wr_vis [NUM_SRC];

    logic [NUM_SRC-1:0] avail;
    logic [NUM_SRC-1:0] full;
    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] drop;
    logic [NUM_SRC-1:0] pop;

    logic [SRC_W-1:0] rr_ptr;
    logic [SRC_W-1:0] grant_idx;
    logic             grant_vld;
    logic             free;
    logic             load_data;
    logic [ENT_W-1:0] head;

    logic             mark_pend;
    logic [15:0]      orbit;
    logic [CNT_W-1:0] n_drop;
    logic [16:0]      drop_sum;

    function automatic int wrap_src(input int i);
        return (i >= NUM_SRC) ? i - NUM_SRC : i;
    endfunction

    // Full is judged on the write pointer seen at the edge, so a same-edge pop never rescues a write.
    always_comb begin
        avail = '0;
        full  = '0;
        push  = '0;
        drop  = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            avail[k] = (wr_vis[k] != rd_ptr[k]);
            full[k]  = (wr_ptr[k][PTR_W] != rd_ptr[k][PTR_W]) &&
                       (wr_ptr[k][PTR_W-1:0] == rd_ptr[k][PTR_W-1:0]);
            push[k]  = src_wr_en[k] && !full[k];
            drop[k]  = src_wr_en[k] && full[k];
        end
    end

    always_comb begin
        free      = !out_valid || out_ready;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            if (!grant_vld && avail[wrap_src(int'(rr_ptr) + i)]) begin
                grant_vld = 1'b1;
                grant_idx = SRC_W'(wrap_src(int'(rr_ptr) + i));
            end
        end
        load_data = free && (state == S_RUN) && !mark_pend && grant_vld;
        pop  = '0;
        head = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            pop[k] = load_data && (grant_idx == SRC_W'(k));
            if (grant_idx == SRC_W'(k))
                head = mem[k][rd_ptr[k][PTR_W-1:0]];
        end
    end

    always_comb begin
        n_drop = '0;
        for (int k = 0; k < NUM_SRC; k++)
            n_drop = n_drop + CNT_W'(drop[k]);
        drop_sum = {1'b0, drop_cnt} + 17'(n_drop);
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_SRC; k++) begin
            if (push[k])
                mem[k][wr_ptr[k][PTR_W-1:0]] <= {src_bx[k*BX_W +: BX_W], src_data[k*DATA_W +: DATA_W]};
        end
    end

    // wr_vis lags wr_ptr by one cycle: a new entry becomes grantable the cycle after it is written.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                wr_ptr[k] <= '0;
                rd_ptr[k] <= '0;
                wr_vis[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_SRC; k++) begin
                if (push[k])
                    wr_ptr[k] <= wr_ptr[k] + PTR_ONE;
                if (pop[k])
                    rd_ptr[k] <= rd_ptr[k] + PTR_ONE;
                wr_vis[k] <= wr_ptr[k];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf      <= '0;
            drop_cnt <= '0;
        end else begin
            ovf      <= ovf | drop;
            drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_RUN;
            rr_ptr     <= SRC_W'(NUM_SRC - 1);
            mark_pend  <= 1'b0;
            orbit      <= '0;
            out_valid  <= 1'b0;
            out_marker <= 1'b0;
            out_src    <= '0;
            out_bx     <= '0;
            out_data   <= '0;
        end else begin
            mark_pend <= mark_pend | BC0;
            case (state)
                S_RUN: begin
                    if (free) begin
                        if (mark_pend) begin
                            state     <= S_MARK;
                            out_valid <= 1'b0;
                        end else if (load_data) begin
                            out_valid         <= 1'b1;
                            out_marker        <= 1'b0;
                            out_src           <= grant_idx;
                            {out_bx, out_data} <= head;
                            rr_ptr            <= grant_idx;
                        end else begin
                            out_valid <= 1'b0;
                        end
                    end
                end
                S_MARK: begin
                    // Output is always idle here: entering S_MARK cleared out_valid.
                    out_valid  <= 1'b1;
                    out_marker <= 1'b1;
                    out_src    <= '1;
                    out_bx     <= '0;
                    out_data   <= DATA_W'(orbit);
                    orbit      <= orbit + 16'd1;
                    mark_pend  <= BC0;
                    state      <= S_RUN;
                end
                default: state <= S_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_spy_readout_arbiter.sv
// Self-checking bench for spy_readout_arbiter: scoreboard of expected output words
// plus a vector table for the round-robin burst and hand-written corner sequences.
module tb_spy_readout_arbiter;

    localparam int NS = 4;
    localparam int DW = 36;
    localparam int BW = 3;
    localparam int SW = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             BC0 = 1'b0;
    logic [NS-1:0]    src_wr_en = '0;
    logic [NS*BW-1:0] src_bx = '0;
    logic [NS*DW-1:0] src_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             out_marker;
    logic [SW-1:0]    out_src;
    logic [BW-1:0]    out_bx;
    logic [DW-1:0]    out_data;
    logic [NS-1:0]    ovf;
    logic [15:0]      drop_cnt;

    spy_readout_arbiter #(
        .NUM_SRC(NS), .DATA_W(DW), .BX_W(BW), .FIFO_DEPTH(8), .SRC_W(SW)
    ) dut (
        .clk(clk), .reset(reset), .BC0(BC0),
        .src_wr_en(src_wr_en), .src_bx(src_bx), .src_data(src_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_marker(out_marker),
        .out_src(out_src), .out_bx(out_bx), .out_data(out_data),
        .ovf(ovf), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          marker;
        logic [SW-1:0] src;
        logic [BW-1:0] bx;
        logic [DW-1:0] data;
    } word_t;

    typedef struct {
        int            cyc;
        int            src;
        logic [BW-1:0] bx;
        logic [DW-1:0] data;
        int            slot;
    } vec_t;

    word_t exp_q[$];
    int    n_checks = 0;
    int    n_fail = 0;
    int    n_markers = 0;
    bit    chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        word_t got;
        word_t e;
        if (chk_en && out_valid && out_ready) begin
            got = {out_marker, out_src, out_bx, out_data};
            if (got.marker)
                n_markers++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_word: got %0h, expected no word", got);
            end else begin
                e = exp_q.pop_front();
                check("word", 64'(got), 64'(e));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int s, input logic [BW-1:0] bx, input logic [DW-1:0] d);
        src_wr_en[s] = 1'b1;
        src_bx[s*BW +: BW] = bx;
        src_data[s*DW +: DW] = d;
    endtask

    task automatic push_exp(input logic m, input int s, input logic [BW-1:0] bx, input logic [DW-1:0] d);
        word_t w;
        w = {m, SW'(s), bx, d};
        exp_q.push_back(w);
    endtask

    task automatic push_marker(input int orbit_n);
        push_exp(1'b1, 15, '0, DW'(orbit_n));
    endtask

    task automatic pulse_bc0();
        BC0 = 1'b1;
        tick();
        BC0 = 1'b0;
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        reset = 1'b0;
        BC0 = 1'b0;
        src_wr_en = '0;
        out_ready = 1'b0;
        repeat (2) tick();
        exp_q.delete();
        reset = 1'b1;
        n_markers = 0;
        chk_en = 1'b1;
        tick();
    endtask

    task automatic drain(input string name, input int budget);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < budget) begin
            tick();
            i++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
        repeat (2) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[8];
        int   n_valid;
        int   first_v;
        int   last_v;

        vecs[0] = '{0, 0, 3'd1, 36'hA_0000_00A0, 0};
        vecs[1] = '{0, 1, 3'd2, 36'h1_0000_11B1, 1};
        vecs[2] = '{0, 2, 3'd3, 36'h2_0000_22C2, 2};
        vecs[3] = '{0, 3, 3'd4, 36'hF_0000_33D3, 3};
        vecs[4] = '{1, 0, 3'd5, 36'h0_FFFF_0FA0, 4};
        vecs[5] = '{1, 1, 3'd6, 36'h5_1234_1FB1, 5};
        vecs[6] = '{1, 2, 3'd7, 36'h6_5678_2FC2, 6};
        vecs[7] = '{1, 3, 3'd0, 36'h7_9ABC_3FD3, 7};

        // Reset values and single-write latency
        repeat (2) tick();
        check("rst_out", {out_valid, out_marker, out_src, out_bx, out_data}, 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        check("rst_drop", 64'(drop_cnt), 64'd0);
        do_reset();
        out_ready = 1'b1;
        push_exp(1'b0, 0, 3'd3, 36'h123);
        set_src(0, 3'd3, 36'h123);
        tick();
        src_wr_en = '0;
        check("lat_t0_valid", 64'(out_valid), 64'd0);
        tick();
        check("lat_t1_valid", 64'(out_valid), 64'd0);
        tick();
        check("lat_t2_valid", 64'(out_valid), 64'd1);
        check("lat_t2_word", 64'({out_marker, out_src, out_bx, out_data}), 64'({1'b0, 4'd0, 3'd3, 36'h123}));
        tick();
        check("lat_t3_valid", 64'(out_valid), 64'd0);
        check("lat_ovf", 64'(ovf), 64'd0);
        check("lat_drop", 64'(drop_cnt), 64'd0);
        drain("lat_drain", 5);

        // Round-robin burst from the vector table
        do_reset();
        out_ready = 1'b1;
        for (int s = 0; s < 8; s++)
            for (int v = 0; v < 8; v++)
                if (vecs[v].slot == s)
                    push_exp(1'b0, vecs[v].src, vecs[v].bx, vecs[v].data);
        for (int c = 0; c < 2; c++) begin
            for (int v = 0; v < 8; v++)
                if (vecs[v].cyc == c)
                    set_src(vecs[v].src, vecs[v].bx, vecs[v].data);
            tick();
            src_wr_en = '0;
        end
        n_valid = 0;
        first_v = -1;
        last_v = -1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) begin
                n_valid++;
                if (first_v < 0)
                    first_v = i;
                last_v = i;
            end
        end
        check("rr_count", 64'(n_valid), 64'd8);
        check("rr_no_gap", 64'(last_v - first_v), 64'd7);
        check("rr_first_slot", 64'(first_v), 64'd0);
        drain("rr_drain", 5);

        // Overflow while stalled behind an occupied output register
        do_reset();
        push_exp(1'b0, 0, 3'd1, 36'hAAA);
        set_src(0, 3'd1, 36'hAAA);
        tick();
        src_wr_en = '0;
        repeat (3) tick();
        check("ovf_stalled_valid", 64'(out_valid), 64'd1);
        for (int i = 0; i < 10; i++) begin
            set_src(2, BW'(i), DW'(36'h200 + i));
            if (i < 8)
                push_exp(1'b0, 2, BW'(i), DW'(36'h200 + i));
            tick();
        end
        src_wr_en = '0;
        tick();
        check("ovf_flags", 64'(ovf), 64'(4'b0100));
        check("ovf_drop_cnt", 64'(drop_cnt), 64'd2);
        out_ready = 1'b1;
        drain("ovf_drain", 40);
        check("ovf_sticky", 64'(ovf), 64'(4'b0100));
        check("ovf_drop_hold", 64'(drop_cnt), 64'd2);

        // BC0 while stalled, then a second BC0, then re-arm in the marker cycle
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_src(1, BW'(i), DW'(36'h100 + i));
            tick();
        end
        src_wr_en = '0;
        repeat (3) tick();
        pulse_bc0();
        repeat (2) tick();
        push_exp(1'b0, 1, 3'd0, 36'h100);
        push_marker(0);
        for (int i = 1; i < 4; i++)
            push_exp(1'b0, 1, BW'(i), DW'(36'h100 + i));
        out_ready = 1'b1;
        drain("bc0_drain", 30);
        push_marker(1);
        pulse_bc0();
        drain("bc0_second", 20);
        push_marker(2);
        push_marker(3);
        BC0 = 1'b1;
        tick();
        BC0 = 1'b0;
        tick();
        BC0 = 1'b1;
        tick();
        BC0 = 1'b0;
        drain("bc0_rearm", 20);
        repeat (5) tick();
        check("bc0_marker_count", 64'(n_markers), 64'd4);

        // Two BC0 pulses while stalled merge into one marker
        do_reset();
        set_src(3, 3'd2, 36'h300);
        tick();
        set_src(3, 3'd5, 36'h301);
        tick();
        src_wr_en = '0;
        repeat (3) tick();
        pulse_bc0();
        tick();
        pulse_bc0();
        push_exp(1'b0, 3, 3'd2, 36'h300);
        push_marker(0);
        push_exp(1'b0, 3, 3'd5, 36'h301);
        out_ready = 1'b1;
        drain("merge_drain", 30);
        repeat (10) tick();
        check("merge_marker_count", 64'(n_markers), 64'd1);

        // Asynchronous reset in the middle of a burst
        do_reset();
        out_ready = 1'b1;
        chk_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            for (int s = 0; s < NS; s++)
                set_src(s, BW'(s), DW'(36'h400 + 16 * s + i));
            tick();
        end
        src_wr_en = '0;
        repeat (2) tick();
        check("burst_active", 64'(out_valid), 64'd1);
        #3;
        reset = 1'b0;
        #1;
        check("async_rst_out", {out_valid, out_marker, out_src, out_bx, out_data}, 64'd0);
        check("async_rst_ovf", 64'(ovf), 64'd0);
        check("async_rst_drop", 64'(drop_cnt), 64'd0);
        repeat (2) tick();
        exp_q.delete();
        reset = 1'b1;
        n_markers = 0;
        chk_en = 1'b1;
        repeat (10) tick();
        check("post_rst_idle", 64'(out_valid), 64'd0);
        push_marker(0);
        pulse_bc0();
        drain("post_rst_marker", 20);
        check("post_rst_marker_count", 64'(n_markers), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spy_readout_arbiter.md
Name: spy_readout_arbiter

Overview:
- Shares one registered output stream (the spy/readout link) among NUM_SRC memory write ports, each presenting the triplet wr_en / BX / data.
- Each source write lands in a per-source FIFO. A round-robin arbiter drains the FIFOs onto the output stream, and each output word carries its source index.
- On BC0 the block inserts a marker word carrying an orbit count, so downstream capture can frame data per orbit.
- Sits between the processing memories' write ports and the readout/capture logic.

Parameters:
- NUM_SRC, 4, number of source write ports (2..16).
- DATA_W, 36, width of the data field of each source.
- BX_W, 3, width of the BX field of each source.
- FIFO_DEPTH, 8, entries per source FIFO (power of 2, at least 4).
- SRC_W, 4, width of the source-index field (2^SRC_W > NUM_SRC).

Ports:
- clk  in  1  system clock, all logic rising-edge.
- reset  in  1  asynchronous, active-low reset.
- BC0  in  1  single-cycle orbit-start pulse.
- src_wr_en  in  NUM_SRC  per-source write strobe.
- src_bx  in  NUM_SRC*BX_W  per-source BX; source k occupies bits [k*BX_W +: BX_W].
- src_data  in  NUM_SRC*DATA_W  per-source data, packed the same way.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accept.
- out_marker  out  1  1 = orbit marker word, 0 = data word.
- out_src  out  SRC_W  source index; all-ones on a marker.
- out_bx  out  BX_W  BX of the word; 0 on a marker.
- out_data  out  DATA_W  data; on a marker, zero-extended 16-bit orbit count.
- ovf  out  NUM_SRC  sticky per-source overflow flag.
- drop_cnt  out  16  total dropped writes, saturating at 0xFFFF.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs 0.
  - FIFOs empty, round-robin pointer = NUM_SRC-1 (so source 0 has first priority).
  - Orbit count 0, marker-pending flag 0, FSM in RUN.
- Capture:
  - src_wr_en[k]=1 pushes {bx, data} into FIFO k on that edge.
  - If FIFO k is full at that edge, the write is dropped, even if a pop of FIFO k occurs on the same edge.
  - A drop sets ovf[k] (cleared only by reset) and increments drop_cnt (saturating).
  - All sources may push on the same cycle; there is no cross-source interaction.
- Output register handshake:
  - The output register is "free" when out_valid=0 or (out_valid & out_ready).
  - When free and a winner exists: load the winner's word, pop it, set out_valid=1.
  - When free and no winner exists: out_valid goes to 0.
  - When out_valid=1 and out_ready=0, all out_* fields hold stable.
- FSM states:
  - RUN: when free and marker-pending=0, grant the first non-empty FIFO in the order ptr+1, ptr+2, … (mod NUM_SRC), then set ptr = granted index. With no non-empty FIFO, nothing is granted.
  - RUN → MARK: when free and marker-pending=1.
  - MARK: load the marker word (out_marker=1, out_src=all-ones, out_bx=0, out_data=orbit count), clear marker-pending, increment orbit count (16-bit wrap, 0xFFFF → 0). Return to RUN the next cycle; no data word is loaded in the same cycle.
- BC0:
  - Sets marker-pending. A marker is therefore emitted at the first free slot after BC0, ahead of any further data words.
  - A second BC0 while one is already pending is merged: only one marker is emitted.
  - BC0 in the same cycle that MARK clears the flag re-arms it (set wins).
  - The first marker after reset carries orbit count 0.
- Latency: a write at edge t into an empty FIFO, with the output idle and no marker pending, gives out_valid=1 after edge t+2. The FIFO is registered; the arbiter sees it non-empty at t+1.
- Throughput: one word per cycle with out_ready held at 1.
- Data order is preserved within a source. Across sources, order follows the round-robin grant.

Test Plan:
- Reset, then src0 writes bx=3, data=0x123 once with out_ready=1 → out_valid=1 exactly 2 cycles later with src=0, bx=3, data=0x123 for 1 cycle; ovf=0, drop_cnt=0.
- All 4 sources write 2 words each in the same 2 cycles, out_ready=1 → output order is src 0,1,2,3,0,1,2,3; no gaps; 8 words total.
- out_ready=0, src2 writes 10 words with FIFO_DEPTH=8 → ovf=4'b0100, drop_cnt=2; after out_ready=1, exactly the first 8 words appear in order.
- BC0 while src1's FIFO holds 3 words and the output is stalled → after release, the in-flight word comes first, then the marker (src=0xF, data=0), then src1's remaining words. A second BC0 → marker with data=1.
- Two BC0 pulses 1 cycle apart while stalled → exactly one marker is emitted.
- Assert reset mid-burst → all outputs 0 immediately. After release, no stale words appear and the next marker carries data=0.
